// File: rtl/drum_pkg.sv
// Shared DRUM datapath definitions: default widths, the shift-width rule
// and the mantissa/shift result bundle used by the core and product shifter.
package drum_pkg;

  localparam int N_DEF = 16;
  localparam int K_DEF = 6;

  function automatic int sw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SW_DEF = sw_of(N_DEF);

  typedef struct packed {
    logic [K_DEF-1:0]  mant;
    logic [SW_DEF-1:0] shift;
    logic              zero;
  } drum_res_t;

endpackage

// File: rtl/drum_steer_pipe_onehot_enc.sv
// One-hot to binary index encoder; reports the highest set bit and
// flags vectors carrying more than one set bit.
module onehot_enc
  import drum_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = sw_of(N)
) (
  input  logic [N-1:0]  vec,
  output logic [SW-1:0] idx,
  output logic          multi
);

  logic seen;

  always_comb begin
    idx   = '0;
    multi = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = SW'(i);
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drum_steer_pipe.sv
// DRUM mantissa steering: encodes the leading-one position and emits the
// truncated K-bit mantissa plus restore shift over a 2-stage pipeline.
module drum_steer_pipe
  import drum_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int K  = K_DEF,
  parameter int SW = sw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [N-1:0]  in_lod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_mant,
  output logic [SW-1:0] out_shift,
  output logic          out_zero,
  output logic          err_lod
);

  localparam logic [SW:0] KW = (SW+1)'(K);

  logic          s1_valid;
  logic          s1_zero;
  logic [N-1:0]  s1_data;
  logic [SW-1:0] s1_pos;
  logic          s2_valid;
  logic          s1_adv;
  logic          in_fire;
  logic          lod_bad;
  logic [SW-1:0] enc_idx;
  logic          enc_multi;
  logic [K-1:0]  mant_d;
  logic [SW-1:0] shift_d;
  logic [N-1:0]  shifted;

  onehot_enc #(
    .N (N),
    .SW(SW)
  ) u_enc (
    .vec  (in_lod),
    .idx  (enc_idx),
    .multi(enc_multi)
  );

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign lod_bad = enc_multi
                 | ((in_lod == '0) && (in_data != '0))
                 | ((in_lod != '0) && ((in_lod & in_data) == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_data  <= '0;
      s1_pos   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_pos  <= enc_idx;
        s1_zero <= (in_lod == '0);
      end
    end
  end

  // Window starts at the leading one; short operands pass through exactly.
  always_comb begin
    mant_d  = '0;
    shift_d = '0;
    shifted = '0;
    if (s1_zero) begin
      mant_d = '0;
    end else if ({1'b0, s1_pos} < KW) begin
      mant_d = s1_data[K-1:0];
    end else begin
      shift_d = s1_pos - SW'(K-1);
      shifted = s1_data >> shift_d;
      mant_d  = shifted[K-1:0] | K'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_mant  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant  <= mant_d;
        out_shift <= shift_d;
        out_zero  <= s1_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_lod <= 1'b0;
    end else if (in_fire && lod_bad) begin
      err_lod <= 1'b1;
    end
  end

endmodule

// File: tb/tb_drum_steer_pipe.sv
// Scoreboard bench for drum_steer_pipe: directed cases, backpressure,
// bad LOD, mid-stream reset and a randomized stream.
module tb_drum_steer_pipe;
  import drum_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_lod;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_mant;
  logic [3:0]  out_shift;
  logic        out_zero;
  logic        err_lod;

  int n_tests;
  int n_fail;

  drum_res_t q[$];
  logic      err_exp;
  logic      have_prev;
  drum_res_t prev;

  drum_steer_pipe #(.N(16), .K(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_lod   (in_lod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mant (out_mant),
    .out_shift(out_shift),
    .out_zero (out_zero),
    .err_lod  (err_lod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic drum_res_t model(input logic [15:0] d,
                                      input logic [15:0] l);
    drum_res_t r;
    int pos;
    int sh;
    pos = -1;
    for (int i = 0; i < 16; i++) if (l[i]) pos = i;
    r.mant  = '0;
    r.shift = '0;
    r.zero  = 1'b0;
    if (pos < 0) begin
      r.zero = 1'b1;
    end else if (pos < 6) begin
      r.mant = 6'(int'(d) % 64);
    end else begin
      sh = pos - 6 + 1;
      r.shift = 4'(sh);
      r.mant  = 6'(((int'(d) >> sh) % 64) | 1);
    end
    return r;
  endfunction

  function automatic logic is_bad(input logic [15:0] d,
                                  input logic [15:0] l);
    return ($countones(l) > 1) || (l == 0 && d != 0)
        || (l != 0 && (l & d) == 0);
  endfunction

  function automatic logic [15:0] hibit(input logic [15:0] d);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (d[i]) r = 16'(1) << i;
    return r;
  endfunction

  // Input-side scoreboard and sticky-error model.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      check("err_lod", {31'd0, err_lod}, {31'd0, err_exp});
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_lod));
        if (is_bad(in_data, in_lod)) err_exp = 1'b1;
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    drum_res_t e;
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev)
        check("stall_hold", {20'd0, out_valid, out_mant, out_shift, out_zero},
              {20'd0, 1'b1, prev.mant, prev.shift, prev.zero});
      if (out_valid && !out_ready) begin
        have_prev  = 1'b1;
        prev.mant  = out_mant;
        prev.shift = out_shift;
        prev.zero  = out_zero;
      end else begin
        have_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("result", {21'd0, out_mant, out_shift, out_zero},
                {21'd0, e.mant, e.shift, e.zero});
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [15:0] l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_lod   = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_op(output logic [15:0] d, output logic [15:0] l);
    int kind;
    kind = $urandom_range(0, 15);
    if (kind == 0) begin
      d = '0;
      l = '0;
    end else if (kind == 1) begin
      d = 16'($urandom);
      l = 16'($urandom);
    end else begin
      d = 16'($urandom) >> $urandom_range(0, 15);
      l = hibit(d);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_outs"}, {21'd0, out_mant, out_shift, out_zero}, 32'd0);
    check({tag, "_err"}, {31'd0, err_lod}, 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] l;
    logic        acc;
    n_tests   = 0;
    n_fail    = 0;
    err_exp   = 1'b0;
    have_prev = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_lod    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    @(posedge clk);
    #1;
    send(16'h1234, 16'h1000);
    @(negedge clk);
    check("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2", {31'd0, out_valid}, 32'd1);
    check("trunc_mant", {26'd0, out_mant}, 32'h25);
    check("trunc_shift", {28'd0, out_shift}, 32'd7);
    send(16'h0013, 16'h0010);
    send(16'hFFFF, 16'h8000);
    send(16'h0000, 16'h0000);
    repeat (4) @(negedge clk);
    check("zero_no_err", {31'd0, err_lod}, 32'd0);

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          rand_op(d, l);
          send(d, hibit(d));
        end
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_no_bubble", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;

    send(16'h00A5, 16'h0081);
    @(negedge clk);
    check("bad_lod_err", {31'd0, err_lod}, 32'd1);
    @(negedge clk);
    check("bad_lod_mant", {26'd0, out_mant}, 32'h29);
    check("bad_lod_shift", {28'd0, out_shift}, 32'd2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom) | 16'h0001;
      send(d, hibit(d));
    end
    repeat (3) @(negedge clk);
    check("bad_lod_sticky", {31'd0, err_lod}, 32'd1);

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(16'h4321, 16'h4000);
    send(16'h0777, 16'h0400);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    rand_op(d, l);
    in_data  = d;
    in_lod   = l;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        rand_op(d, l);
        in_data  = d;
        in_lod   = l;
        in_valid = ($urandom_range(0, 3) != 0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
